fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the single-issue RISC-V core. Holds the program counter, drives the byte address into the asynchronous instruction ROM, and captures the returned 32-bit word into the IF/ID pipeline register consumed by decode. Supports decode-side stall and execute-side redirect (branch/jump) with flush of the fetched-but-wrong instruction.

## Interface
Parameters:
- ADDRESS_WIDTH, 12, width of the ROM byte address and of the PC
- RESET_PC, 0, PC value loaded on reset (must be a multiple of 4)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  decode cannot accept; hold PC and IF/ID register
- redirect_valid  input  1  execute resolved a taken branch/jump this cycle
- redirect_target  input  ADDRESS_WIDTH  new PC when redirect_valid=1
- pc_o  output  ADDRESS_WIDTH  byte address driven to the ROM (combinational from PC register)
- instr_i  input  32  little-endian word returned combinationally by the ROM for pc_o
- if_valid  output  1  IF/ID register holds a real instruction
- if_pc  output  ADDRESS_WIDTH  address of if_instr
- if_pc_plus4  output  ADDRESS_WIDTH  if_pc + 4, modulo 2^ADDRESS_WIDTH
- if_instr  output  32  captured instruction; NOP (32'h0000_0013) when if_valid=0
- misalign_err  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: PC register; IF/ID register {if_valid, if_pc, if_pc_plus4, if_instr}; misalign_err flop.
- pc_o = PC register directly; no combinational path from any input to pc_o.
- Per-edge priority, highest first:
  - rst: PC<=RESET_PC; if_valid<=0; if_pc<=0; if_pc_plus4<=0; if_instr<=NOP; misalign_err<=0.
  - redirect_valid: PC<=redirect_target (aligned per Configuration); IF/ID flushed (if_valid<=0, if_instr<=NOP, if_pc/if_pc_plus4 unchanged). Applies even when stall=1.
  - stall: PC and IF/ID hold all values.
  - otherwise: IF/ID<={1, PC, PC+4, instr_i}; PC<=PC+4.
- PC+4 wraps modulo 2^ADDRESS_WIDTH (e.g. 12'hFFC -> 12'h000). PC is always word-aligned, so ROM bytes PC..PC+3 never straddle the wrap.
- Redirect and stall in the same cycle: redirect wins; the stalled instruction in IF/ID is discarded.
- Reset mid-stall or mid-redirect: reset wins; first valid instruction out of IF/ID is the word at RESET_PC, one edge after rst deasserts.

## Timing
- Fetch latency: 1 cycle from PC register to if_instr (ROM is combinational).
- After rst deasserts at edge N: edge N+1 presents word@RESET_PC with if_valid=1.
- Redirect asserted before edge N: edge N has if_valid=0 (bubble); edge N+1 presents word@target with if_valid=1. Taken-branch penalty = 1 fetched slot plus whatever decode already held.
- Stall asserted before edge N: outputs at N equal outputs at N-1; release resumes with no lost or duplicated instruction.
- Steady state, no stall: one instruction per cycle, if_pc advancing by 4.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_target[1:0]!=0 is not taken (PC advances/holds as if redirect_valid=0, no flush) and misalign_err sets to 1, held until rst.
- Undefined: redirect_target[1:0] forced to 2'b00 before loading PC; misalign_err tied to 0.

## Test plan
- Reset then free-run, RESET_PC=0, ROM words W0..W3: if_valid=0 during reset; edges 1..4 give if_pc=0,4,8,C with if_instr=W0..W3, if_pc_plus4=4,8,C,10.
- Stall for 3 cycles at if_pc=8: if_pc=8, if_instr=W2 held 3 cycles, pc_o held at C; release gives if_pc=C next edge.
- Redirect to 12'h040 while if_pc=4: next edge if_valid=0, if_instr=32'h0000_0013; following edge if_pc=040, if_instr=word@040.
- Redirect and stall simultaneously, target 12'h100: redirect taken, bubble, then if_pc=100.
- PC wrap: RESET_PC=12'hFF8, free-run: if_pc=FF8, FFC, 000 with if_pc_plus4 of FFC = 000.
- Misaligned redirect to 12'h042: with FETCH_MISALIGN_CHECK_EN, no flush, sequential fetch continues, misalign_err=1 until rst; without it, PC loads 12'h040, misalign_err=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the single-issue RISC-V core.
//
// Holds the PC, drives it straight to the asynchronous instruction ROM and
// captures the returned word into the IF/ID register read by decode.
// Decode can stall the stage. Execute can redirect it (taken branch/jump),
// which flushes the instruction that was fetched down the wrong path.
//
// Optional feature (macro FETCH_MISALIGN_CHECK_EN):
//   defined   - a redirect whose target is not word-aligned is ignored and
//               the sticky misalign_err flag is set (cleared only by rst).
//   undefined - target[1:0] is forced to 2'b00; misalign_err is tied to 0.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   stall            decode cannot accept; PC and IF/ID hold
//   redirect_valid   execute requests a new PC (wins over stall)
//   redirect_target  the new PC
//   pc_o             ROM byte address (the PC register itself)
//   instr_i          ROM word for pc_o
//   if_valid/if_pc/if_pc_plus4/if_instr   IF/ID register (NOP when invalid)
//   misalign_err     sticky misaligned-redirect flag
module fetch_stage #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  input  logic [31:0]              instr_i,
  output logic                     if_valid,
  output logic [ADDRESS_WIDTH-1:0] if_pc,
  output logic [ADDRESS_WIDTH-1:0] if_pc_plus4,
  output logic [31:0]              if_instr,
  output logic                     misalign_err
);

  localparam logic [ADDRESS_WIDTH-1:0] RESET_PC_V = ADDRESS_WIDTH'(RESET_PC);
  localparam logic [31:0]              NOP        = 32'h0000_0013;

  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic                     r_if_valid;
  logic [ADDRESS_WIDTH-1:0] r_if_pc;
  logic [ADDRESS_WIDTH-1:0] r_if_pc_plus4;
  logic [31:0]              r_if_instr;

  logic                     w_redirect_take;
  logic [ADDRESS_WIDTH-1:0] w_redirect_pc;
  logic [ADDRESS_WIDTH-1:0] w_pc_plus4;

  // Wraps naturally modulo 2^ADDRESS_WIDTH.
  assign w_pc_plus4 = r_pc + ADDRESS_WIDTH'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign_err;
  logic w_misaligned;

  assign w_misaligned    = redirect_valid && (redirect_target[1:0] != 2'b00);
  // A misaligned redirect behaves exactly as if no redirect were requested.
  assign w_redirect_take = redirect_valid && !w_misaligned;
  assign w_redirect_pc   = redirect_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else if (w_misaligned) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign misalign_err = r_misalign_err;
`else
  assign w_redirect_take = redirect_valid;
  assign w_redirect_pc   = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
  assign misalign_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC_V;
      r_if_valid    <= 1'b0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_instr    <= NOP;
    end else if (w_redirect_take) begin
      // Flush: if_pc/if_pc_plus4 deliberately keep their old values.
      r_pc       <= w_redirect_pc;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP;
    end else if (!stall) begin
      r_pc          <= w_pc_plus4;
      r_if_valid    <= 1'b1;
      r_if_pc       <= r_pc;
      r_if_pc_plus4 <= w_pc_plus4;
      r_if_instr    <= instr_i;
    end
  end

  assign pc_o        = r_pc;
  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign if_instr    = r_if_instr;

endmodule
